// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, next-PC selection, alignment/range
// fault detection, halt handling and a saturating retired-instruction counter.
module pc_fetch #(
  parameter int                 DWIDTH    = 32,
  parameter int                 WIDTH     = 8,
  parameter logic [DWIDTH-1:0]  BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        pc_src,
  input  logic [DWIDTH-1:0] imm,
  input  logic [DWIDTH-1:0] jalr_target,
  input  logic              halt_req,
  input  logic [DWIDTH-1:0] instr_in,
  output logic [WIDTH-1:0]  A,
  output logic [DWIDTH-1:0] instr_out,
  output logic [DWIDTH-1:0] pc_out,
  output logic [DWIDTH-1:0] pc_plus4,
  output logic              valid,
  output logic              halted,
  output logic              fault,
  output logic [DWIDTH-1:0] fault_pc,
  output logic [31:0]       retired
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_HALT  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  localparam logic [DWIDTH-1:0] NOP_INSTR = DWIDTH'(32'h0000_0013);
  localparam logic [DWIDTH-1:0] PC_STEP   = DWIDTH'(4);
  localparam logic [DWIDTH-1:0] BIT0_MASK = ~DWIDTH'(1);

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   pc_q, pc_d;
  logic [DWIDTH-1:0]   fault_pc_q, fault_pc_d;
  logic [31:0]         retired_q, retired_d;

  logic [DWIDTH-1:0]   seq_pc;
  logic [DWIDTH-1:0]   next_pc;
  logic                next_bad;
  logic [31:0]         retired_inc;

  assign seq_pc = pc_q + PC_STEP;

  // Next-PC mux; all sums wrap naturally at DWIDTH bits.
  always_comb begin
    next_pc = seq_pc;
    unique case (pc_src)
      2'b01:   next_pc = pc_q + imm;
      2'b10:   next_pc = jalr_target & BIT0_MASK;
      default: next_pc = seq_pc;
    endcase
  end

  // Misaligned, or beyond the byte-addressable instruction memory.
  assign next_bad = (next_pc[1:0] != 2'b00) || ((next_pc >> WIDTH) != '0);

  assign retired_inc = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    retired_d  = retired_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_d   = S_HALT;
            retired_d = retired_inc;
          end else if (next_bad) begin
            state_d    = S_FAULT;
            fault_pc_d = next_pc;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_inc;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= BOOT_ADDR;
      fault_pc_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      retired_q  <= retired_d;
    end
  end

  assign A         = pc_q[WIDTH-1:0];
  assign pc_out    = pc_q;
  assign pc_plus4  = seq_pc;
  assign valid     = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);
  assign fault     = (state_q == S_FAULT);
  assign fault_pc  = fault_pc_q;
  assign retired   = retired_q;
  assign instr_out = valid ? instr_in : NOP_INSTR;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch: sequential fetch, branches,
// stall, halt, faults and asynchronous reset, against hand-computed values.
module tb_pc_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] jalr_target;
  logic        halt_req;
  logic [31:0] instr_in;
  logic [7:0]  A;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        halted;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] retired;

  logic [31:0] imem [64];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pc_fetch #(.DWIDTH(32), .WIDTH(8), .BOOT_ADDR(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_src      (pc_src),
    .imm         (imm),
    .jalr_target (jalr_target),
    .halt_req    (halt_req),
    .instr_in    (instr_in),
    .A           (A),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .valid       (valid),
    .halted      (halted),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .retired     (retired)
  );

  assign instr_in = imem[A[7:2]];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset, then release it on a falling edge; leaves the DUT in BOOT.
  task automatic do_reset();
    rst         = 1'b1;
    stall       = 1'b0;
    pc_src      = 2'b00;
    imm         = '0;
    jalr_target = '0;
    halt_req    = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 | 32'(i);
    imem[0] = 32'h0030_0093;
    imem[1] = 32'h0090_0113;
    imem[2] = 32'h0020_8133;
    imem[3] = 32'h0020_f1b3;

    // Reset state, checked while rst is held high.
    rst         = 1'b1;
    stall       = 1'b0;
    pc_src      = 2'b00;
    imm         = '0;
    jalr_target = '0;
    halt_req    = 1'b0;
    #1;
    check("rst_pc",       pc_out,   32'h0);
    check("rst_valid",    32'(valid),  32'h0);
    check("rst_halted",   32'(halted), 32'h0);
    check("rst_fault",    32'(fault),  32'h0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_retired",  retired,  32'h0);
    check("rst_instr",    instr_out, NOP);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Sequential fetch.
    check("boot_valid", 32'(valid), 32'h0);
    check("boot_instr", instr_out,  NOP);
    check("boot_A",     32'(A),     32'h00);
    step();
    check("seq0_A",       32'(A),     32'h00);
    check("seq0_valid",   32'(valid), 32'h1);
    check("seq0_instr",   instr_out,  32'h0030_0093);
    check("seq0_retired", retired,    32'h0);
    step();
    check("seq1_A",     32'(A),    32'h04);
    check("seq1_instr", instr_out, 32'h0090_0113);
    step();
    check("seq2_A",     32'(A),    32'h08);
    check("seq2_instr", instr_out, 32'h0020_8133);
    step();
    check("seq3_A",       32'(A),    32'h0C);
    check("seq3_instr",   instr_out, 32'h0020_f1b3);
    check("seq3_retired", retired,   32'h3);
    check("seq3_plus4",   pc_plus4,  32'h10);

    // Backward branch then jalr with bit0 cleared, then misaligned jalr.
    do_reset();
    step(3);
    check("br_start_pc", pc_out, 32'h08);
    pc_src = 2'b01;
    imm    = 32'hFFFF_FFF8;
    step();
    check("br_pc",      pc_out,  32'h00);
    check("br_retired", retired, 32'h3);
    pc_src      = 2'b10;
    jalr_target = 32'h15;
    step();
    check("jalr_pc",      pc_out,  32'h14);
    check("jalr_A",       32'(A),  32'h14);
    check("jalr_retired", retired, 32'h4);
    jalr_target = 32'h17;
    step();
    check("jalr_mis_fault",    32'(fault), 32'h1);
    check("jalr_mis_fault_pc", fault_pc,   32'h16);
    check("jalr_mis_pc",       pc_out,     32'h14);
    check("jalr_mis_retired",  retired,    32'h4);

    // Stall overrides branch and halt; then halt.
    do_reset();
    step(2);
    check("stall_start_pc", pc_out, 32'h04);
    stall    = 1'b1;
    pc_src   = 2'b01;
    imm      = 32'h40;
    halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",      pc_out,      32'h04);
      check("stall_retired", retired,     32'h1);
      check("stall_valid",   32'(valid),  32'h1);
      check("stall_halted",  32'(halted), 32'h0);
      check("stall_instr",   instr_out,   32'h0090_0113);
    end
    stall = 1'b0;
    step();
    check("halt_halted",  32'(halted), 32'h1);
    check("halt_valid",   32'(valid),  32'h0);
    check("halt_instr",   instr_out,   NOP);
    check("halt_pc",      pc_out,      32'h04);
    check("halt_retired", retired,     32'h2);
    halt_req = 1'b0;
    imm      = 32'h8;
    step(2);
    check("halt_hold_pc",      pc_out,      32'h04);
    check("halt_hold_halted",  32'(halted), 32'h1);
    check("halt_hold_retired", retired,     32'h2);

    // Misaligned branch target faults.
    do_reset();
    step();
    pc_src = 2'b01;
    imm    = 32'h6;
    step();
    check("mis_fault",    32'(fault),  32'h1);
    check("mis_fault_pc", fault_pc,    32'h06);
    check("mis_pc",       pc_out,      32'h00);
    check("mis_retired",  retired,     32'h0);
    check("mis_halted",   32'(halted), 32'h0);
    check("mis_valid",    32'(valid),  32'h0);
    pc_src = 2'b00;
    step();
    check("mis_hold_fault_pc", fault_pc, 32'h06);
    check("mis_hold_pc",       pc_out,   32'h00);

    // Halt wins over a simultaneous fault.
    do_reset();
    step();
    pc_src   = 2'b01;
    imm      = 32'h6;
    halt_req = 1'b1;
    step();
    check("hpri_halted",   32'(halted), 32'h1);
    check("hpri_fault",    32'(fault),  32'h0);
    check("hpri_fault_pc", fault_pc,    32'h0);
    check("hpri_retired",  retired,     32'h1);
    check("hpri_pc",       pc_out,      32'h00);

    // Sequential run-off past top of memory, then async reset in FAULT.
    do_reset();
    step();
    pc_src = 2'b01;
    imm    = 32'hFC;
    step();
    check("top_pc",      pc_out,  32'hFC);
    check("top_retired", retired, 32'h1);
    pc_src = 2'b00;
    step();
    check("top_fault",    32'(fault), 32'h1);
    check("top_fault_pc", fault_pc,   32'h100);
    check("top_pc_hold",  pc_out,     32'hFC);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc",       pc_out,     32'h0);
    check("arst_fault",    32'(fault), 32'h0);
    check("arst_retired",  retired,    32'h0);
    check("arst_fault_pc", fault_pc,   32'h0);
    check("arst_valid",    32'(valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_boot_valid", 32'(valid), 32'h0);
    step();
    check("arst_run_valid", 32'(valid), 32'h1);
    check("arst_run_instr", instr_out,  32'h0030_0093);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning instruction and PC data width.
REQ-002 SHALL have parameter WIDTH, default 8, meaning instruction-memory byte-address width.
REQ-003 SHALL have parameter BOOT_ADDR, default 0, meaning the PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port stall, input, 1, which freezes all fetch state when high.
REQ-007 SHALL have port pc_src, input, 2, next-PC select: 00 = PC+4, 01 = PC+imm, 10 = jalr_target, 11 = PC+4.
REQ-008 SHALL have port imm, input, DWIDTH, the branch/jal offset in bytes (signed).
REQ-009 SHALL have port jalr_target, input, DWIDTH, the rs1+imm sum from the ALU.
REQ-010 SHALL have port halt_req, input, 1, which is high when the current instruction is EBREAK.
REQ-011 SHALL have port instr_in, input, DWIDTH, the instruction-memory read data (RD).
REQ-012 SHALL have port A, output, WIDTH, the instruction-memory address.
REQ-013 SHALL have port instr_out, output, DWIDTH, the instruction sent to decode.
REQ-014 SHALL have port pc_out, output, DWIDTH, the current PC.
REQ-015 SHALL have port pc_plus4, output, DWIDTH, the current PC+4, used as the jal/jalr link value.
REQ-016 SHALL have port valid, output, 1, which is high when instr_out is a real fetched instruction.
REQ-017 SHALL have ports halted and fault, outputs, 1 each, which are sticky terminal-state flags.
REQ-018 SHALL have port fault_pc, output, DWIDTH, the offending next-PC value that caused a fault.
REQ-019 SHALL have port retired, output, 32, the count of retired instructions.

Function
REQ-020 SHALL implement FSM states BOOT, RUN, HALT and FAULT.
REQ-021 SHALL go from BOOT to RUN unconditionally after one cycle, with valid=0 while in BOOT.
REQ-022 SHALL drive A = pc_out[WIDTH-1:0] combinationally.
REQ-023 SHALL drive instr_out = instr_in when valid=1, and 0x00000013 (NOP) otherwise.
REQ-024 SHALL drive valid=1 only in RUN.
REQ-025 SHALL compute all next-PC arithmetic modulo 2^DWIDTH.
REQ-026 SHALL form the jalr next-PC as jalr_target with bit0 cleared.
REQ-027 SHALL, in RUN with stall=1, hold PC, state and retired, with outputs stable; stall SHALL override halt_req and pc_src.
REQ-028 SHALL, in RUN with stall=0 and halt_req=1, enter HALT, hold PC and increment retired; halt_req SHALL take priority over any fault on the same cycle.
REQ-029 SHALL, in RUN with stall=0 and halt_req=0, enter FAULT with PC held, fault_pc=next-PC and retired unchanged when next-PC[1:0]!=0 or next-PC >= 2^WIDTH (this includes sequential PC+4 run-off past the top of memory).
REQ-030 SHALL otherwise, in RUN with stall=0, load PC with next-PC and increment retired.
REQ-031 SHALL make retired saturate at 0xFFFFFFFF and never wrap.
REQ-032 SHALL make HALT and FAULT terminal until rst, with valid=0, PC frozen and all inputs ignored.
REQ-033 SHALL drive halted=1 exactly in HALT and fault=1 exactly in FAULT.
REQ-034 SHALL hold fault_pc at 0 except in FAULT.

Reset
REQ-035 SHALL, while rst=1 and independent of clk, force state=BOOT, PC=BOOT_ADDR, retired=0, fault_pc=0, halted=0, fault=0 and valid=0.
REQ-036 SHALL, on rst assertion mid-operation (including while in HALT or FAULT), discard all state immediately and restart from BOOT after rst deasserts.
REQ-037 SHALL keep rst deassertion out of any clk edge setup/hold window; the bench SHALL deassert rst on the falling edge.

Verification
REQ-038 SHALL cover: rst pulse, then pc_src=00 for 4 edges -> BOOT cycle with valid=0, then A=0x00,0x04,0x08,0x0C; instr_out 0x00300093,0x00900113,0x00208133,0x0020f1b3; retired=3.
REQ-039 SHALL cover: at PC=0x08, pc_src=01 with imm=0xFFFFFFF8 -> PC=0x00; then pc_src=10 with jalr_target=0x15 -> PC=0x14.
REQ-040 SHALL cover: at PC=0x04, stall=1 for 3 cycles with pc_src=01 and halt_req=1 -> PC=0x04, retired unchanged, valid=1; after stall drops, halt_req=1 -> halted=1, valid=0, instr_out=0x00000013.
REQ-041 SHALL cover: pc_src=01 with imm=0x6 from PC=0x00 -> fault=1, fault_pc=0x06, PC=0x00; the same with halt_req=1 -> halted=1 and fault=0.
REQ-042 SHALL cover: PC=0xFC with pc_src=00 -> fault=1, fault_pc=0x100.
REQ-043 SHALL cover: rst asserted mid-cycle while in FAULT -> immediate PC=0, fault=0, retired=0 before the next edge.
